// File: rtl/spi_log_pkg.sv
// Shared constants for the SPI command log: iomem register offsets, CTRL bit
// positions, the unmapped-read pattern and log-entry field widths.
package spi_log_pkg;

    localparam logic [7:0] SPI_LOG_STATUS = 8'h00;
    localparam logic [7:0] SPI_LOG_HEAD0  = 8'h04;
    localparam logic [7:0] SPI_LOG_HEAD1  = 8'h08;
    localparam logic [7:0] SPI_LOG_HEAD2  = 8'h0C;
    localparam logic [7:0] SPI_LOG_POP    = 8'h10;
    localparam logic [7:0] SPI_LOG_CTRL   = 8'h14;
    localparam logic [7:0] SPI_LOG_FILTER = 8'h18;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam logic [31:0] SPI_LOG_DEFAULT_RDATA = 32'hDECA_FBAD;

    // Entry layout, MSB first: {ts, cmd, addr, len}
    localparam int ENT_CMD_W   = 8;
    localparam int ENT_ADDR_W  = 32;
    localparam int HEAD0_TS_W  = 24;

    function automatic int entry_width(input int ts_w, input int len_w);
        return ts_w + ENT_CMD_W + ENT_ADDR_W + len_w;
    endfunction

endpackage

// File: rtl/spi_log_fifo.sv
// Generic synchronous FIFO with clear, occupancy count and a combinational
// head word. Pop on empty is ignored; push when full only lands with a pop.
module spi_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_eff;
    logic             push_eff;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push_eff} - {{AW{1'b0}}, pop_eff};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; empty state is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_eff && !clear) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/spi_cmd_log.sv
// Timestamped FIFO log of emulated-flash SPI commands on the picosoc iomem bus.
// Optional command filter register at 0x18 is built when SPI_LOG_FILTER_EN is defined.
module spi_cmd_log
    import spi_log_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int TS_WIDTH    = 24,
    parameter int TS_DIV_LOG2 = 4,
    parameter int LEN_WIDTH   = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 spi_cmd_strobe,
    input  logic [7:0]           spi_cmd,
    input  logic [31:0]          spi_addr,
    input  logic [LEN_WIDTH-1:0] spi_len,
    input  logic                 sel,
    input  logic [7:0]           addr,
    input  logic [3:0]           wstrb,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic                 irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = TS_WIDTH + TS_DIV_LOG2;
    localparam int EW = entry_width(TS_WIDTH, LEN_WIDTH);

    logic [CW-1:0]  tsc_q, tsc_d;
    logic [15:0]    ovf_q, ovf_d;
    logic           enable_q, enable_d;
    logic           ready_q, ready_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    rd_val;

    logic [EW-1:0]  fifo_din, fifo_head;
    logic [AW:0]    fifo_count;
    logic           fifo_full, fifo_empty;

    logic           wr_act, pop_req, ctrl_wr, clear, push_req, ovf_inc, cmd_match;
    logic           unused_bits;

    // Bus writes act in the ready cycle, so each transaction fires exactly once.
    assign wr_act   = ready_q && sel && (wstrb != 4'b0000);
    assign pop_req  = wr_act && (addr == SPI_LOG_POP);
    assign ctrl_wr  = wr_act && (addr == SPI_LOG_CTRL) && wstrb[0];
    assign clear    = ctrl_wr && wdata[CTRL_CLEAR_BIT];
    assign push_req = spi_cmd_strobe && enable_q && cmd_match;
    assign ovf_inc  = push_req && fifo_full && !pop_req && !clear;

`ifdef SPI_LOG_FILTER_EN
    logic [15:0] filter_q, filter_d;

    assign cmd_match = ((spi_cmd & filter_q[15:8]) == filter_q[7:0]);

    always_comb begin
        filter_d = filter_q;
        if (wr_act && (addr == SPI_LOG_FILTER)) begin
            if (wstrb[0]) filter_d[7:0]  = wdata[7:0];
            if (wstrb[1]) filter_d[15:8] = wdata[15:8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) filter_q <= '0;
        else         filter_q <= filter_d;
    end
`else
    assign cmd_match = 1'b1;
`endif

    assign fifo_din = {tsc_q[CW-1:TS_DIV_LOG2], spi_cmd, spi_addr, spi_len};

    spi_log_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .pop    (pop_req),
        .clear  (clear),
        .din    (fifo_din),
        .head   (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        rd_val = SPI_LOG_DEFAULT_RDATA;
        case (addr)
            SPI_LOG_STATUS: rd_val = {ovf_q, 7'b0, fifo_full, 8'(fifo_count)};
            SPI_LOG_HEAD0:  rd_val = fifo_empty ? 32'h0 :
                                     32'({fifo_head[EW-1 -: TS_WIDTH],
                                          fifo_head[LEN_WIDTH+ENT_ADDR_W +: ENT_CMD_W]});
            SPI_LOG_HEAD1:  rd_val = fifo_empty ? 32'h0 : fifo_head[LEN_WIDTH +: ENT_ADDR_W];
            SPI_LOG_HEAD2:  rd_val = fifo_empty ? 32'h0 : 32'(fifo_head[LEN_WIDTH-1:0]);
            SPI_LOG_POP:    rd_val = 32'h0;
            SPI_LOG_CTRL:   rd_val = 32'(enable_q);
`ifdef SPI_LOG_FILTER_EN
            SPI_LOG_FILTER: rd_val = 32'(filter_q);
`else
            SPI_LOG_FILTER: rd_val = 32'h0;
`endif
            default:        rd_val = SPI_LOG_DEFAULT_RDATA;
        endcase
    end

    always_comb begin
        tsc_d    = tsc_q + 1'b1;
        ovf_d    = ovf_q;
        enable_d = enable_q;
        ready_d  = sel && !ready_q;
        rdata_d  = (sel && !ready_q) ? rd_val : 32'h0;
        if (clear)
            ovf_d = '0;
        else if (ovf_inc && (ovf_q != 16'hFFFF))
            ovf_d = ovf_q + 16'd1;
        if (ctrl_wr)
            enable_d = wdata[CTRL_ENABLE_BIT];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tsc_q    <= '0;
            ovf_q    <= '0;
            enable_q <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            tsc_q    <= tsc_d;
            ovf_q    <= ovf_d;
            enable_q <= enable_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign irq   = enable_q && !fifo_empty;

    assign unused_bits = ^wdata;

endmodule

// File: tb/tb_spi_cmd_log.sv
// Scoreboard bench for spi_cmd_log: expected entries are queued as strobes are
// driven and checked against HEAD reads as the log is drained.
module tb_spi_cmd_log;

    localparam int DEPTH = 16;

    logic        clk;
    logic        resetn;
    logic        spi_cmd_strobe;
    logic [7:0]  spi_cmd;
    logic [31:0] spi_addr;
    logic [11:0] spi_len;
    logic        sel;
    logic [7:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    spi_cmd_log #(
        .DEPTH       (16),
        .TS_WIDTH    (24),
        .TS_DIV_LOG2 (4),
        .LEN_WIDTH   (12)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .spi_cmd_strobe (spi_cmd_strobe),
        .spi_cmd        (spi_cmd),
        .spi_addr       (spi_addr),
        .spi_len        (spi_len),
        .sel            (sel),
        .addr           (addr),
        .wstrb          (wstrb),
        .wdata          (wdata),
        .rdata          (rdata),
        .ready          (ready),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference clock count since reset release; its upper bits are the 1 us tick.
    logic [27:0] cyc;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= '0;
        else         cyc <= cyc + 28'd1;
    end

    typedef struct {
        logic [23:0] ts;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [11:0] len;
    } ent_t;

    ent_t        sb[$];
    int          m_ovf;
    bit          m_en;
    logic [15:0] m_filter;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] exp_status();
        return {16'(m_ovf), 7'b0, (sb.size() == DEPTH), 8'(sb.size())};
    endfunction

    function automatic void model_strobe(input logic [7:0] c, input logic [31:0] a,
                                         input logic [11:0] l);
        ent_t e;
        if (!m_en) return;
`ifdef SPI_LOG_FILTER_EN
        if ((c & m_filter[15:8]) != m_filter[7:0]) return;
`endif
        if (sb.size() < DEPTH) begin
            e.ts = cyc[27:4]; e.cmd = c; e.addr = a; e.len = l;
            sb.push_back(e);
        end else if (m_ovf < 65535) begin
            m_ovf++;
        end
    endfunction

    // All tasks start and end on a falling edge.
    task automatic do_strobe(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
        spi_cmd_strobe = 1'b1; spi_cmd = c; spi_addr = a; spi_len = l;
        model_strobe(c, a, l);
        @(negedge clk);
        spi_cmd_strobe = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
        int n;
        sel = 1'b1; addr = off; wstrb = 4'h0; d = 'x;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 8);
        vectors++;
        if (!ready) begin
            miscompares++;
            $display("FAIL read_timeout off=%02h: ready=%b required 1", off, ready);
        end else begin
            d = rdata;
        end
        @(posedge clk); @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [31:0] wd, input bit with_strobe,
                             input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
        int n;
        bit old_en;
        sel = 1'b1; addr = off; wdata = wd; wstrb = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 8);
        vectors++;
        if (!ready) begin
            miscompares++;
            $display("FAIL write_timeout off=%02h: ready=%b required 1", off, ready);
        end else begin
            if (with_strobe) begin
                spi_cmd_strobe = 1'b1; spi_cmd = c; spi_addr = a; spi_len = l;
            end
            old_en = m_en;
            if (off == 8'h14 && wd[1]) begin
                sb.delete();
                m_ovf = 0;
            end else begin
                if (off == 8'h10 && sb.size() > 0) void'(sb.pop_front());
                if (with_strobe) model_strobe(c, a, l);
            end
            m_en = old_en;
            if (off == 8'h14) m_en = wd[0];
            if (off == 8'h18) m_filter = wd[15:0];
        end
        @(posedge clk); @(negedge clk);
        sel = 1'b0; wstrb = 4'h0; spi_cmd_strobe = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        resetn = 1'b0; spi_cmd_strobe = 1'b0; spi_cmd = '0; spi_addr = '0; spi_len = '0;
        sel = 1'b0; addr = '0; wstrb = '0; wdata = '0;
        sb.delete(); m_ovf = 0; m_en = 1'b0; m_filter = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ready, irq, rdata} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b irq=%b rdata=%08h required 0/0/0", ready, irq, rdata);
        end
        resetn = 1'b1;
        @(negedge clk);
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL reset_status: got %08h required 00000000", d);
        end
        bus_read(8'h14, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL reset_ctrl: got %08h required 00000000", d);
        end
        $display("test_reset done");
    endtask

    task automatic test_drain;
        logic [31:0] d0, d1, d2;
        ent_t e;
        while (sb.size() > 0) begin
            e = sb[0];
            bus_read(8'h04, d0);
            bus_read(8'h08, d1);
            bus_read(8'h0C, d2);
            vectors++;
            if ({d0, d1, d2} !== {e.ts, e.cmd, e.addr, 20'h0, e.len}) begin
                miscompares++;
                $display("FAIL drain_head: got %08h/%08h/%08h required %08h/%08h/%08h",
                         d0, d1, d2, {e.ts, e.cmd}, e.addr, {20'h0, e.len});
            end
            $display("drain: ts=%06h cmd=%02h addr=%08h len=%03h", d0[31:8], d0[7:0], d1, d2[11:0]);
            bus_write(8'h10, 32'h1, 1'b0, 8'h0, 32'h0, 12'h0);
        end
        bus_read(8'h00, d0);
        vectors++;
        if (d0 !== exp_status()) begin
            miscompares++; $display("FAIL drain_status: got %08h required %08h", d0, exp_status());
        end
    endtask

    task automatic test_basic;
        logic [31:0] d, ts_a;
        logic [7:0]  cmds [3];
        cmds[0] = 8'h03; cmds[1] = 8'h0B; cmds[2] = 8'h02;
        bus_write(8'h14, 32'h1, 1'b0, 8'h0, 32'h0, 12'h0);
        for (int i = 0; i < 3; i++) begin
            do_strobe(cmds[i], 32'(i + 1) << 12, 12'h10 + 12'(i));
            if (i == 0) begin
                vectors++;
                if (irq !== 1'b1) begin
                    miscompares++; $display("FAIL irq_latency: irq=%b required 1", irq);
                end
            end
            if (i < 2) repeat (79) @(negedge clk);
        end
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h3 || irq !== 1'b1) begin
            miscompares++; $display("FAIL basic_status: got %08h irq=%b required 00000003 irq=1", d, irq);
        end
        bus_read(8'h04, ts_a);
        vectors++;
        if (ts_a[7:0] !== 8'h03) begin
            miscompares++; $display("FAIL basic_cmd0: got %02h required 03", ts_a[7:0]);
        end
        bus_write(8'h10, 32'h1, 1'b0, 8'h0, 32'h0, 12'h0);
        bus_read(8'h04, d);
        vectors++;
        if (d[31:8] - ts_a[31:8] !== 24'd5) begin
            miscompares++; $display("FAIL basic_ts_delta: got %0d required 5", d[31:8] - ts_a[31:8]);
        end
        test_drain();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL basic_irq_clear: irq=%b required 0", irq);
        end
        $display("test_basic done");
    endtask

    task automatic test_disabled;
        logic [31:0] d;
        bus_write(8'h14, 32'h0, 1'b0, 8'h0, 32'h0, 12'h0);
        for (int i = 0; i < 3; i++) do_strobe(8'h9F, 32'h40 * i, 12'h4);
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL disabled_status: got %08h required 00000000", d);
        end
        bus_write(8'h10, 32'h1, 1'b0, 8'h0, 32'h0, 12'h0);
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL pop_empty_status: got %08h required 00000000", d);
        end
        bus_read(8'h04, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL empty_head0: got %08h required 00000000", d);
        end
        $display("test_disabled done");
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        bus_write(8'h14, 32'h1, 1'b0, 8'h0, 32'h0, 12'h0);
        for (int i = 0; i < 20; i++) do_strobe(8'h0B, 32'h100 + 32'(i), 12'(i));
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h0004_0110) begin
            miscompares++; $display("FAIL ovf_status: got %08h required 00040110", d);
        end
        bus_read(8'h08, d);
        vectors++;
        if (d !== 32'h100) begin
            miscompares++; $display("FAIL ovf_head_addr: got %08h required 00000100", d);
        end
        bus_write(8'h10, 32'h1, 1'b1, 8'h0B, 32'h200, 12'h7);
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h0004_0110) begin
            miscompares++; $display("FAIL full_push_pop: got %08h required 00040110", d);
        end
        test_drain();
        $display("test_overflow done");
    endtask

    task automatic test_clear;
        logic [31:0] d;
        for (int i = 0; i < 18; i++) do_strobe(8'h02, 32'h500 + 32'(i), 12'h1);
        bus_read(8'h00, d);
        vectors++;
        if (d !== exp_status()) begin
            miscompares++; $display("FAIL clear_pre_status: got %08h required %08h", d, exp_status());
        end
        bus_write(8'h14, 32'h3, 1'b1, 8'h02, 32'h999, 12'h1);
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL clear_status: got %08h required 00000000", d);
        end
        bus_read(8'h14, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++; $display("FAIL clear_ctrl_readback: got %08h required 00000001", d);
        end
        $display("test_clear done");
    endtask

    task automatic test_filter;
        logic [31:0] d;
`ifdef SPI_LOG_FILTER_EN
        bus_write(8'h18, 32'hFF02, 1'b0, 8'h0, 32'h0, 12'h0);
        bus_read(8'h18, d);
        vectors++;
        if (d !== 32'hFF02) begin
            miscompares++; $display("FAIL filter_readback: got %08h required 0000ff02", d);
        end
`else
        bus_write(8'h18, 32'hFF02, 1'b0, 8'h0, 32'h0, 12'h0);
        bus_read(8'h18, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL filter_absent: got %08h required 00000000", d);
        end
`endif
        do_strobe(8'h02, 32'hA0, 12'h2);
        do_strobe(8'h03, 32'hA1, 12'h3);
        do_strobe(8'h02, 32'hA2, 12'h4);
        bus_read(8'h00, d);
        vectors++;
        if (d !== exp_status()) begin
            miscompares++; $display("FAIL filter_status: got %08h required %08h", d, exp_status());
        end
        test_drain();
`ifdef SPI_LOG_FILTER_EN
        bus_write(8'h18, 32'h0, 1'b0, 8'h0, 32'h0, 12'h0);
`endif
        $display("test_filter done");
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) do_strobe(8'h03, 32'h700 + 32'(i), 12'h8);
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h4) begin
            miscompares++; $display("FAIL mid_pre_status: got %08h required 00000004", d);
        end
        sel = 1'b1; addr = 8'h00; wstrb = 4'h0;
        #2 resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ready !== 1'b0) begin
                miscompares++; $display("FAIL mid_ready_%0d: ready=%b required 0", i, ready);
            end
        end
        resetn = 1'b1; sel = 1'b0;
        sb.delete(); m_ovf = 0; m_en = 1'b0; m_filter = '0;
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL mid_irq: irq=%b required 0", irq);
        end
        bus_read(8'h00, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL mid_status: got %08h required 00000000", d);
        end
        bus_read(8'h14, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL mid_ctrl: got %08h required 00000000", d);
        end
        bus_read(8'h20, d);
        vectors++;
        if (d !== 32'hDECAFBAD) begin
            miscompares++; $display("FAIL unmapped_read: got %08h required decafbad", d);
        end
        bus_write(8'h14, 32'h1, 1'b0, 8'h0, 32'h0, 12'h0);
        do_strobe(8'hEB, 32'hCAFE, 12'hABC);
        test_drain();
        $display("test_reset_mid done");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_disabled();
        test_overflow();
        test_clear();
        test_filter();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
